fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of each requester's data word and of the FIFO write data, SHALL be provided.
REQ-002 Parameter NUM_REQ, 4, number of requesters (2..8), SHALL be provided.
REQ-003 Parameter BURST_LEN, 4, maximum words pushed per grant (1..16), SHALL be provided.
REQ-004 wr_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 req  in  NUM_REQ  per-requester request; held high while the requester has a word on req_data.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fifo_full  in  1  FIFO write-side full.
REQ-009 fifo_afull  in  1  FIFO write-side almost-full.
REQ-010 push  out  1  FIFO write strobe.
REQ-011 datain  out  DATA_WIDTH  FIFO write data.
REQ-012 gnt  out  NUM_REQ  one-hot registered grant; all zero when idle.
REQ-013 ack  out  NUM_REQ  ack[i] high in exactly the cycles where requester i's word is pushed; requester i SHALL present its next word in the following cycle.
REQ-014 burst_done  out  1  one-cycle pulse, registered, the cycle after a burst ends.

Function
REQ-015 FSM SHALL have two states: IDLE and BURST.
REQ-016 IDLE -> BURST when any req bit is high and fifo_afull=0; gnt SHALL be loaded with the round-robin winner on that edge; otherwise stay IDLE with gnt=0.
REQ-017 Round-robin: search starts at (last_grant+1) mod NUM_REQ, ascending with wrap; the first asserted req wins; last_grant SHALL be updated to the winner's index when the grant is loaded.
REQ-018 In BURST with granted index g: push = req[g] & ~fifo_full (combinational); datain = req_data slice g (combinational mux); ack = gnt when push=1, else 0.
REQ-019 Latency: first push SHALL occur in the first cycle after the IDLE->BURST edge (one cycle after the arbitration cycle).
REQ-020 beat_cnt (4 bits) SHALL reset to 0 on grant load and increment on every push.
REQ-021 BURST -> IDLE on the push with beat_cnt = BURST_LEN-1, or in any cycle where req[g]=0 (early termination, no push that cycle); gnt SHALL clear on that edge and burst_done SHALL pulse the next cycle.
REQ-022 fifo_full=1 in BURST with req[g]=1 SHALL stall: no push, no ack, beat_cnt held, state held; pushing resumes the first cycle fifo_full=0.
REQ-023 push SHALL never be asserted while fifo_full=1 and SHALL be 0 in IDLE.
REQ-024 A requester SHALL NOT be regranted back-to-back while any other req bit is high; with a single requester active, a new burst SHALL start after exactly one IDLE cycle.
REQ-025 req changes on non-granted requesters during BURST SHALL have no effect until the next IDLE arbitration.
REQ-026 fifo_afull is sampled only in IDLE; fifo_afull rising mid-burst SHALL NOT terminate the burst.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force: state IDLE, gnt=0, beat_cnt=0, last_grant=NUM_REQ-1, burst_done=0; hence push=0, ack=0, datain=req_data slice 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further push from the cycle after the reset edge; no burst_done pulse is generated for the aborted burst.
REQ-029 After reset deassertion, first arbitration SHALL favour requester 0.

Verification (NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=8)
REQ-030 Single requester: req=4'b0010 held, data 0x10,0x11,... advanced on ack -> gnt=4'b0010 one cycle after req; pushes 0x10..0x13 on 4 consecutive cycles; burst_done pulse; one IDLE cycle; next burst pushes 0x14..0x17.
REQ-031 All requesters: req=4'b1111 held -> grant order 0,1,2,3,0; each burst exactly 4 pushes; ack one-hot matches gnt on every push.
REQ-032 Backpressure: fifo_full=1 for 3 cycles after second push of a burst -> push=0 for those 3 cycles, beat_cnt holds at 2, remaining 2 words pushed after release, total 4, no word lost or duplicated.
REQ-033 Early termination: req[2] drops after 2 pushes -> state IDLE next edge, burst_done pulses, next grant goes to next requester with req high after index 2.
REQ-034 Almost-full gate: fifo_afull=1 with req=4'b0001 -> gnt stays 0, no push; fifo_afull deasserts -> gnt=4'b0001 next edge.
REQ-035 Reset mid-burst: reset_n=0 after 1 push -> gnt=0, push=0 next cycle; after release with req=4'b1100, first grant is requester 2 per round-robin from last_grant=3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST_LEN pushes into a FIFO, honouring full/almost-full backpressure.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          wr_clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic                          fifo_full,
   input  logic                          fifo_afull,
   output logic                          push,
   output logic [DATA_WIDTH-1:0]         datain,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          burst_done
);

   localparam int            IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [3:0]    LAST_BEAT = 4'(BURST_LEN - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state, state_n;
   logic [IW-1:0]         gidx, gidx_n;
   logic [IW-1:0]         last_grant, last_grant_n;
   logic [IW-1:0]         win, cand;
   logic                  found;
   logic [NUM_REQ-1:0]    gnt_n;
   logic [3:0]            beat_cnt, beat_cnt_n;
   logic                  done_n;
   logic                  cur_req;
   logic [DATA_WIDTH-1:0] words [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
      assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search begins just past the last winner so a requester cannot be
   // regranted while anyone else is waiting.
   always_comb begin
      win   = last_grant;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n      = state;
      gidx_n       = gidx;
      last_grant_n = last_grant;
      gnt_n        = gnt;
      beat_cnt_n   = beat_cnt;
      done_n       = 1'b0;
      cur_req      = req[gidx];
      push         = 1'b0;
      case (state)
         IDLE: begin
            gnt_n = '0;
            if (found && !fifo_afull) begin
               state_n      = BURST;
               gidx_n       = win;
               last_grant_n = win;
               gnt_n        = NUM_REQ'(1) << win;
               beat_cnt_n   = '0;
            end
         end
         BURST: begin
            push = cur_req & ~fifo_full;
            // A dropped request ends the burst without a push that cycle.
            if (!cur_req) begin
               state_n = IDLE;
               gnt_n   = '0;
               done_n  = 1'b1;
            end else if (push) begin
               beat_cnt_n = beat_cnt + 4'd1;
               if (beat_cnt == LAST_BEAT) begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  done_n  = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign ack    = push ? gnt : '0;
   assign datain = words[gidx];

   always_ff @(posedge wr_clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         gnt        <= '0;
         gidx       <= '0;
         last_grant <= LAST_IDX;
         beat_cnt   <= '0;
         burst_done <= 1'b0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         gidx       <= gidx_n;
         last_grant <= last_grant_n;
         beat_cnt   <= beat_cnt_n;
         burst_done <= done_n;
      end
   end

endmodule
